// File: rtl/floo_mesh_fabric.sv
// 2D-mesh link fabric: wires every tile port N/E/S/W to the opposite port of
// its neighbour through LinkStages elastic stages per channel. Off-mesh ports
// sink their flits and report the drops (saturating count, sticky flag and
// coordinates of the first drop).
//
// Handshake (every channel, both directions): a flit moves when valid && ready
// are both high on a rising clock edge. Once valid is raised, valid and data
// hold steady until that transfer happens. ready may change freely.
//
// Port vectors are flattened. The flat index is ((x*MeshY + y)*4 + d)*NumChan + c.
// Payload for that index sits at data[idx*DataWidth +: DataWidth].

// Elastic stage holding two entries. valid_o and ready_o come from registers
// only, so no combinational path crosses the stage. It passes one flit per
// cycle with one cycle of latency.
module floo_link_stage #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o
);
  logic [DataWidth-1:0] mem_q [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 push, pop;

  assign ready_o = (cnt_q != 2'd2);
  assign valid_o = (cnt_q != 2'd0);
  // An empty stage presents zero data instead of a stale entry.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  // Update the occupancy count and the read/write pointers.
  always_comb begin
    cnt_d    = cnt_q + 2'(push) - 2'(pop);
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
  end

  // Control state. Reset empties the stage and discards any flits in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage. It needs no reset because the output is masked when empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module floo_mesh_fabric #(
  parameter int unsigned MeshX      = 4,
  parameter int unsigned MeshY      = 4,
  parameter int unsigned NumChan    = 3,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned LinkStages = 1,
  parameter int unsigned CntWidth   = 16,
  localparam int unsigned NumPorts  = MeshX * MeshY * 4 * NumChan,
  localparam int unsigned XW        = (MeshX > 1) ? $clog2(MeshX) : 1,
  localparam int unsigned YW        = (MeshY > 1) ? $clog2(MeshY) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts-1:0]           tile_valid_i,
  output logic [NumPorts-1:0]           tile_ready_o,
  input  logic [NumPorts*DataWidth-1:0] tile_data_i,
  output logic [NumPorts-1:0]           tile_valid_o,
  input  logic [NumPorts-1:0]           tile_ready_i,
  output logic [NumPorts*DataWidth-1:0] tile_data_o,
  input  logic                          clr_i,
  output logic [CntWidth-1:0]           drop_cnt_o,
  output logic                          drop_err_o,
  output logic [XW-1:0]                 drop_x_o,
  output logic [YW-1:0]                 drop_y_o,
  output logic [1:0]                    drop_dir_o
);
  localparam int unsigned PcW = $clog2(NumPorts + 1);
  localparam int unsigned SW  = CntWidth + PcW;

  logic [NumPorts-1:0] bnd_mask;
  logic [NumPorts-1:0] drop_vec;
  logic [NumPorts-1:0] unused_bits;

  for (genvar gx = 0; gx < MeshX; gx++) begin : g_x
    for (genvar gy = 0; gy < MeshY; gy++) begin : g_y
      for (genvar gd = 0; gd < 4; gd++) begin : g_d
        localparam int Nx  = (gd == 1) ? gx + 1 : (gd == 3) ? gx - 1 : gx;
        localparam int Ny  = (gd == 0) ? gy + 1 : (gd == 2) ? gy - 1 : gy;
        localparam bit Bnd = (Nx < 0) || (Nx >= int'(MeshX)) ||
                             (Ny < 0) || (Ny >= int'(MeshY));
        for (genvar gc = 0; gc < NumChan; gc++) begin : g_c
          localparam int Idx  = ((gx * MeshY + gy) * 4 + gd) * NumChan + gc;
          localparam int NIdx = ((Nx * MeshY + Ny) * 4 + (gd ^ 2)) * NumChan + gc;
          if (Bnd) begin : g_bnd
            // Off-mesh port: always accept the leaving flit and sink it. Never present an entering flit.
            assign bnd_mask[Idx]     = 1'b1;
            assign tile_ready_o[Idx] = 1'b1;
            assign tile_valid_o[Idx] = 1'b0;
            assign tile_data_o[Idx*DataWidth +: DataWidth] = '0;
            assign unused_bits[Idx]  = ^{tile_ready_i[Idx], tile_data_i[Idx*DataWidth +: DataWidth]};
          end else begin : g_link
            logic [LinkStages:0] ch_v;
            logic [LinkStages:0] ch_r;
            logic [DataWidth-1:0] ch_d [LinkStages+1];
            assign bnd_mask[Idx]     = 1'b0;
            assign unused_bits[Idx]  = 1'b0;
            assign ch_v[0]           = tile_valid_i[Idx];
            assign ch_d[0]           = tile_data_i[Idx*DataWidth +: DataWidth];
            assign tile_ready_o[Idx] = ch_r[0];
            for (genvar gs = 0; gs < LinkStages; gs++) begin : g_stage
              floo_link_stage #(.DataWidth(DataWidth)) u_stage (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .valid_i(ch_v[gs]),
                .ready_o(ch_r[gs]),
                .data_i (ch_d[gs]),
                .valid_o(ch_v[gs+1]),
                .ready_i(ch_r[gs+1]),
                .data_o (ch_d[gs+1])
              );
            end
            assign tile_valid_o[NIdx] = ch_v[LinkStages];
            assign tile_data_o[NIdx*DataWidth +: DataWidth] = ch_d[LinkStages];
            assign ch_r[LinkStages]   = tile_ready_i[NIdx];
          end
        end
      end
    end
  end

  // Boundary ready is constant 1, so every valid boundary flit is a drop.
  assign drop_vec = tile_valid_i & bnd_mask;

  logic [PcW-1:0]      drop_num;
  logic [SW-1:0]       cnt_sum;
  logic [XW-1:0]       first_x;
  logic [YW-1:0]       first_y;
  logic [1:0]          first_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [1:0]          dir_q, dir_d;

  // Count the drops in this cycle and find the lowest-index dropping port.
  // The scan runs downward, so the lowest index is written last and wins.
  always_comb begin
    drop_num = '0;
    first_x  = '0;
    first_y  = '0;
    first_d  = '0;
    for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
      drop_num = drop_num + PcW'(drop_vec[i]);
      if (drop_vec[i]) begin
        first_x = XW'(i / int'(MeshY * 4 * NumChan));
        first_y = YW'((i / int'(4 * NumChan)) % int'(MeshY));
        first_d = 2'((i / int'(NumChan)) % 4);
      end
    end
    cnt_sum = SW'(cnt_q) + SW'(drop_num);
  end

  // Next state of the drop counter (saturating), sticky flag and first-drop capture. clr_i overrides a drop in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    x_d   = x_q;
    y_d   = y_q;
    dir_d = dir_q;
    if (clr_i) begin
      cnt_d = '0;
      err_d = 1'b0;
      x_d   = '0;
      y_d   = '0;
      dir_d = '0;
    end else begin
      cnt_d = (cnt_sum > SW'({CntWidth{1'b1}})) ? {CntWidth{1'b1}} : cnt_sum[CntWidth-1:0];
      if (!err_q && (|drop_vec)) begin
        err_d = 1'b1;
        x_d   = first_x;
        y_d   = first_y;
        dir_d = first_d;
      end
    end
  end

  // Drop bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      dir_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      x_q   <= x_d;
      y_q   <= y_d;
      dir_q <= dir_d;
    end
  end

  assign drop_cnt_o = cnt_q;
  assign drop_err_o = err_q;
  assign drop_x_o   = x_q;
  assign drop_y_o   = y_q;
  assign drop_dir_o = dir_q;
endmodule
